multicycle_control: RTL and testbench

//   Multicycle control FSM that sits directly upstream of the ALU. Captures the

---
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle IF/ID/EX/MEM/WB control FSM for an RV32I subset
// The IR is captured on the fetch edge, and all datapath controls are decoded from it.
module multicycle_control #(
  parameter logic [31:0] RESET_IR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic [2:0]  state,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] f3_op;
  logic [3:0] dec_op;
  logic       dec_src;
  logic       is_arith, is_lw, is_sw, is_beq, is_illegal;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      ir_q    <= RESET_IR;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Plain funct3 map shared by R-type and I-type; 011 (sltu) has no code here.
  always_comb begin
    f3_op = ALU_ADD;
    case (funct3)
      3'b000:  f3_op = ALU_ADD;
      3'b111:  f3_op = ALU_AND;
      3'b110:  f3_op = ALU_OR;
      3'b100:  f3_op = ALU_XOR;
      3'b010:  f3_op = ALU_SLT;
      3'b001:  f3_op = ALU_SLL;
      3'b101:  f3_op = ALU_SRL;
      default: f3_op = ALU_ADD;
    endcase
  end

  always_comb begin
    dec_op   = ALU_ADD;
    dec_src  = 1'b0;
    is_arith = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_beq   = 1'b0;
    case (opcode)
      OPC_R: begin
        is_arith = (funct7 == F7_ZERO && funct3 != 3'b011) ||
                   (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
        if (funct7 == F7_ALT)
          dec_op = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
        else
          dec_op = f3_op;
        dec_src = 1'b0;
      end
      OPC_I: begin
        // Only the shift-immediates carry a funct7 field worth checking.
        is_arith = (funct3 != 3'b011) &&
                   ((funct3 != 3'b001 && funct3 != 3'b101) ||
                    funct7 == F7_ZERO ||
                    (funct3 == 3'b101 && funct7 == F7_ALT));
        dec_op  = (funct3 == 3'b101 && funct7 == F7_ALT) ? ALU_SRA : f3_op;
        dec_src = 1'b1;
      end
      OPC_LW: begin
        is_lw   = (funct3 == 3'b010);
        dec_op  = ALU_ADD;
        dec_src = 1'b1;
      end
      OPC_SW: begin
        is_sw   = (funct3 == 3'b010);
        dec_op  = ALU_ADD;
        dec_src = 1'b1;
      end
      OPC_BEQ: begin
        is_beq  = (funct3 == 3'b000);
        dec_op  = ALU_SUB;
        dec_src = 1'b0;
      end
      default: begin
        dec_op  = ALU_ADD;
        dec_src = 1'b0;
      end
    endcase
    if (!(is_arith || is_lw || is_sw || is_beq)) begin
      dec_op  = ALU_ADD;
      dec_src = 1'b0;
    end
  end

  assign is_illegal = !(is_arith || is_lw || is_sw || is_beq);

  always_comb begin
    state_d    = S_IF;
    ir_d       = ir_q;
    alu_op     = ALU_ADD;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_IF: begin
        state_d = S_ID;
        ir_d    = instr;
      end
      S_ID: begin
        state_d = S_EX;
        alu_op  = dec_op;
        alu_src = dec_src;
      end
      S_EX: begin
        alu_op  = dec_op;
        alu_src = dec_src;
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_arith) begin
          state_d = S_WB;
        end else begin
          // beq and illegal both retire here
          state_d  = S_IF;
          pc_write = 1'b1;
          pc_src   = is_beq ? zero : 1'b0;
          illegal  = is_illegal;
        end
      end
      S_MEM: begin
        alu_op  = dec_op;
        alu_src = dec_src;
        if (is_lw) begin
          state_d  = S_WB;
          mem_read = 1'b1;
        end else begin
          state_d   = S_IF;
          mem_write = is_sw;
          pc_write  = 1'b1;
        end
      end
      S_WB: begin
        state_d    = S_IF;
        alu_op     = dec_op;
        alu_src    = dec_src;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = is_lw;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
// Each instruction is checked cycle by cycle against a hand-written control vector.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic [3:0]  alu_op;
  logic        alu_src, mem_read, mem_write, mem_to_reg, reg_write;
  logic        pc_write, pc_src, illegal;
  logic [2:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [14:0] e [0:5];

  multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .zero       (zero),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .state      (state),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // flags = {alu_src, mem_read, mem_write, mem_to_reg, reg_write, pc_write, pc_src, illegal}
  function automatic logic [14:0] cv(input logic [2:0] st, input logic [3:0] op,
                                     input logic [7:0] flags);
    return {st, op, flags};
  endfunction

  function automatic logic [14:0] observed();
    return {state, alu_op, alu_src, mem_read, mem_write, mem_to_reg,
            reg_write, pc_write, pc_src, illegal};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Starts in S_IF at a sample point; IR must ignore instr after the fetch edge.
  task automatic run_instr(input string tag, input logic [31:0] ins, input logic z, input int n);
    instr = ins;
    zero  = z;
    check($sformatf("%s c0", tag), {17'd0, observed()}, {17'd0, e[0]});
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      instr = 32'hFFFFFFFF;
      check($sformatf("%s c%0d", tag, i), {17'd0, observed()}, {17'd0, e[i]});
    end
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    instr = 32'h0;
    zero  = 1'b0;
    #2;
    check("reset", {17'd0, observed()}, {17'd0, cv(3'd0, 4'b0010, 8'b0)});
    @(negedge clk);
    rst = 1'b0;

    // add x3,x1,x2
    e[0] = cv(3'd0, 4'b0010, 8'b0000_0000);
    e[1] = cv(3'd1, 4'b0010, 8'b0000_0000);
    e[2] = cv(3'd2, 4'b0010, 8'b0000_0000);
    e[3] = cv(3'd4, 4'b0010, 8'b0000_1100);
    run_instr("add", 32'h002081B3, 1'b0, 4);

    // lw x5,8(x1)
    e[0] = cv(3'd0, 4'b0010, 8'b0000_0000);
    e[1] = cv(3'd1, 4'b0010, 8'b1000_0000);
    e[2] = cv(3'd2, 4'b0010, 8'b1000_0000);
    e[3] = cv(3'd3, 4'b0010, 8'b1100_0000);
    e[4] = cv(3'd4, 4'b0010, 8'b1001_1100);
    run_instr("lw", 32'h0080A283, 1'b0, 5);

    // beq taken, then not taken
    e[0] = cv(3'd0, 4'b0010, 8'b0000_0000);
    e[1] = cv(3'd1, 4'b0110, 8'b0000_0000);
    e[2] = cv(3'd2, 4'b0110, 8'b0000_0110);
    run_instr("beq_z1", 32'h00208463, 1'b1, 3);
    e[2] = cv(3'd2, 4'b0110, 8'b0000_0100);
    run_instr("beq_z0", 32'h00208463, 1'b0, 3);

    // srai x1,x1,3
    e[0] = cv(3'd0, 4'b0010, 8'b0000_0000);
    e[1] = cv(3'd1, 4'b1010, 8'b1000_0000);
    e[2] = cv(3'd2, 4'b1010, 8'b1000_0000);
    e[3] = cv(3'd4, 4'b1010, 8'b1000_1100);
    run_instr("srai", 32'h4030D093, 1'b0, 4);

    // sw
    e[0] = cv(3'd0, 4'b0010, 8'b0000_0000);
    e[1] = cv(3'd1, 4'b0010, 8'b1000_0000);
    e[2] = cv(3'd2, 4'b0010, 8'b1000_0000);
    e[3] = cv(3'd3, 4'b0010, 8'b1010_0100);
    run_instr("sw", 32'h0020A223, 1'b0, 4);

    // all-ones opcode
    e[0] = cv(3'd0, 4'b0010, 8'b0000_0000);
    e[1] = cv(3'd1, 4'b0010, 8'b0000_0000);
    e[2] = cv(3'd2, 4'b0010, 8'b0000_0101);
    run_instr("illegal", 32'hFFFFFFFF, 1'b0, 3);

    // sub x3,x1,x2 and xori x1,x1,5 for broader decode coverage
    e[0] = cv(3'd0, 4'b0010, 8'b0000_0000);
    e[1] = cv(3'd1, 4'b0110, 8'b0000_0000);
    e[2] = cv(3'd2, 4'b0110, 8'b0000_0000);
    e[3] = cv(3'd4, 4'b0110, 8'b0000_1100);
    run_instr("sub", 32'h402081B3, 1'b0, 4);
    e[1] = cv(3'd1, 4'b1101, 8'b1000_0000);
    e[2] = cv(3'd2, 4'b1101, 8'b1000_0000);
    e[3] = cv(3'd4, 4'b1101, 8'b1000_1100);
    run_instr("xori", 32'h0050C093, 1'b0, 4);

    // R-type with a bad funct7 is illegal
    e[1] = cv(3'd1, 4'b0010, 8'b0000_0000);
    e[2] = cv(3'd2, 4'b0010, 8'b0000_0101);
    run_instr("bad_f7", 32'h022081B3, 1'b0, 3);

    // reset pulsed in S_MEM of lw
    instr = 32'h0080A283;
    check("rst_lw IF", {29'd0, state}, 32'd0);
    @(negedge clk);
    instr = 32'hFFFFFFFF;
    @(negedge clk);
    @(negedge clk);
    check("rst_lw MEM", {17'd0, observed()}, {17'd0, cv(3'd3, 4'b0010, 8'b1100_0000)});
    #1 rst = 1'b1;
    #1;
    check("rst_lw state", {29'd0, state}, 32'd0);
    check("rst_lw mem_read", {31'd0, mem_read}, 32'd0);
    #1 rst = 1'b0;

    e[0] = cv(3'd0, 4'b0010, 8'b0000_0000);
    e[1] = cv(3'd1, 4'b0010, 8'b0000_0000);
    e[2] = cv(3'd2, 4'b0010, 8'b0000_0000);
    e[3] = cv(3'd4, 4'b0010, 8'b0000_1100);
    run_instr("add_after_rst", 32'h002081B3, 1'b0, 4);
    check("final IF", {29'd0, state}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
